decode_ctrl_stage: RTL and testbench

Parametrised successor to the combinational instruction decoder, with a registered ID/EX boundary. It fully decodes RV32I: ALU op, operand muxes, immediate, branch condition, load/store control, writeback select and illegal-instruction flag. Each decoded instruction is held in an output pipeline register with a valid/ready handshake. The block also detects load-use hazards and inserts one bubble for each, honours a pipeline flush, and counts stall cycles.

---
 rtl/decode_ctrl_stage.sv | 216 +++++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_stage.sv
// RV32I decode stage with a registered ID/EX boundary, valid/ready handshake,
// load-use bubble insertion, flush handling and a saturating stall counter.
module decode_ctrl_stage #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16,
    parameter int HAZARD_EN  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [31:0]           instr_i,
    input  logic [XLEN-1:0]       pc_i,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic                  flush_i,
    output logic                  ex_valid_o,
    input  logic                  ex_ready_i,
    output logic [XLEN-1:0]       pc_o,
    output logic [3:0]            alu_op_o,
    output logic                  data_a_mux_o,
    output logic                  data_b_mux_o,
    output logic [XLEN-1:0]       imm_o,
    output logic [ADDR_WIDTH-1:0] reg_raddr_a_o,
    output logic [ADDR_WIDTH-1:0] reg_raddr_b_o,
    output logic [ADDR_WIDTH-1:0] reg_waddr_o,
    output logic                  reg_we_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [1:0]            mem_size_o,
    output logic                  mem_sign_ext_o,
    output logic [2:0]            branch_mux_o,
    output logic [1:0]            wdata_mux_o,
    output logic                  jal_op_o,
    output logic                  jalr_op_o,
    output logic                  illegal_instr_o,
    output logic                  stall_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);
    localparam logic [6:0] OPC_LUI    = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL  = 7'h6F,
                           OPC_JALR   = 7'h67, OPC_BRANCH = 7'h63, OPC_LOAD = 7'h03,
                           OPC_STORE  = 7'h23, OPC_OPIMM = 7'h13, OPC_OP   = 7'h33,
                           OPC_MISC   = 7'h0F, OPC_SYSTEM = 7'h73;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [3:0]            alu_op;
        logic                  a_mux;
        logic                  b_mux;
        logic [XLEN-1:0]       imm;
        logic [ADDR_WIDTH-1:0] waddr;
        logic                  we;
        logic                  mem_req;
        logic                  mem_we;
        logic [1:0]            mem_size;
        logic                  sign_ext;
        logic [2:0]            branch;
        logic [1:0]            wdata;
        logic                  jal;
        logic                  jalr;
        logic                  illegal;
    } ctrl_t;

    ctrl_t                 dec, ctrl_d, ctrl_q;
    logic                  valid_d, valid_q;
    logic [CNT_WIDTH-1:0]  cnt_d, cnt_q;
    logic [6:0]            opc, f7;
    logic [2:0]            f3;
    logic [31:0]           imm32, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [3:0]            alu_f3;
    logic                  rs1_used, rs2_used, hazard, accept;

    assign opc   = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        alu_f3 = ALU_ADD;
        unique case (f3)
            3'd0: alu_f3 = ALU_ADD;
            3'd1: alu_f3 = ALU_SLL;
            3'd2: alu_f3 = ALU_SLT;
            3'd3: alu_f3 = ALU_SLTU;
            3'd4: alu_f3 = ALU_XOR;
            3'd5: alu_f3 = f7[5] ? ALU_SRA : ALU_SRL;
            3'd6: alu_f3 = ALU_OR;
            3'd7: alu_f3 = ALU_AND;
        endcase
    end

    always_comb begin
        dec       = '0;
        imm32     = '0;
        dec.pc    = pc_i;
        dec.waddr = ADDR_WIDTH'(instr_i[11:7]);
        unique case (opc)
            OPC_LUI:    begin imm32 = imm_u; dec.b_mux = 1'b1; dec.we = 1'b1; end
            OPC_AUIPC:  begin imm32 = imm_u; dec.a_mux = 1'b1; dec.b_mux = 1'b1; dec.we = 1'b1; end
            OPC_JAL:    begin imm32 = imm_j; dec.a_mux = 1'b1; dec.b_mux = 1'b1; dec.we = 1'b1;
                              dec.wdata = 2'd2; dec.jal = 1'b1; end
            OPC_JALR:   begin imm32 = imm_i; dec.b_mux = 1'b1; dec.we = 1'b1;
                              dec.wdata = 2'd2; dec.jalr = 1'b1; end
            OPC_BRANCH: begin
                imm32 = imm_b;
                dec.alu_op = ALU_SUB;
                unique case (f3)
                    3'd0: dec.branch = 3'd1;
                    3'd1: dec.branch = 3'd2;
                    3'd4: dec.branch = 3'd3;
                    3'd5: dec.branch = 3'd4;
                    3'd6: dec.branch = 3'd5;
                    3'd7: dec.branch = 3'd6;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_LOAD:   begin
                imm32 = imm_i; dec.b_mux = 1'b1; dec.we = 1'b1; dec.wdata = 2'd1;
                dec.mem_req  = 1'b1;
                dec.mem_size = f3[1:0];
                dec.sign_ext = ~f3[2];
                dec.illegal  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            OPC_STORE:  begin
                imm32 = imm_s; dec.b_mux = 1'b1; dec.mem_req = 1'b1; dec.mem_we = 1'b1;
                dec.mem_size = f3[1:0];
                dec.illegal  = (f3 > 3'd2);
            end
            OPC_OPIMM:  begin
                imm32 = imm_i; dec.b_mux = 1'b1; dec.we = 1'b1; dec.alu_op = alu_f3;
                dec.illegal = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                              ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
            end
            OPC_OP:     begin
                dec.we     = 1'b1;
                dec.alu_op = ((f3 == 3'd0) && f7[5]) ? ALU_SUB : alu_f3;
                dec.illegal = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
            end
            OPC_MISC, OPC_SYSTEM: imm32 = imm_i;
            default:    dec.illegal = 1'b1;
        endcase
        dec.imm = XLEN'($signed(imm32));
        // Illegal instructions travel down the pipe but must not cause side effects.
        if (dec.illegal) begin
            dec.we = 1'b0; dec.mem_req = 1'b0; dec.mem_we = 1'b0; dec.mem_size = 2'd0;
            dec.sign_ext = 1'b0; dec.branch = 3'd0; dec.wdata = 2'd0;
            dec.jal = 1'b0; dec.jalr = 1'b0;
        end
    end

    assign rs1_used = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    assign rs2_used = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    assign reg_raddr_a_o = (opc == OPC_LUI) ? '0 : ADDR_WIDTH'(instr_i[19:15]);
    assign reg_raddr_b_o = ADDR_WIDTH'(instr_i[24:20]);

    assign hazard = (HAZARD_EN != 0) && valid_q && ctrl_q.mem_req && !ctrl_q.mem_we &&
                    (ctrl_q.waddr != '0) &&
                    ((rs1_used && (reg_raddr_a_o == ctrl_q.waddr)) ||
                     (rs2_used && (reg_raddr_b_o == ctrl_q.waddr)));

    assign instr_ready_o = flush_i || ((!valid_q || ex_ready_i) && !hazard);
    assign stall_o       = hazard && !flush_i;
    assign accept        = instr_valid_i && instr_ready_o && !flush_i;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            ctrl_d  = dec;
        end else if (ex_ready_i) begin
            valid_d = 1'b0;
        end
        if (stall_o && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid_o      = valid_q;
    assign pc_o            = ctrl_q.pc;
    assign alu_op_o        = ctrl_q.alu_op;
    assign data_a_mux_o    = ctrl_q.a_mux;
    assign data_b_mux_o    = ctrl_q.b_mux;
    assign imm_o           = ctrl_q.imm;
    assign reg_waddr_o     = ctrl_q.waddr;
    assign reg_we_o        = ctrl_q.we;
    assign mem_req_o       = ctrl_q.mem_req;
    assign mem_we_o        = ctrl_q.mem_we;
    assign mem_size_o      = ctrl_q.mem_size;
    assign mem_sign_ext_o  = ctrl_q.sign_ext;
    assign branch_mux_o    = ctrl_q.branch;
    assign wdata_mux_o     = ctrl_q.wdata;
    assign jal_op_o        = ctrl_q.jal;
    assign jalr_op_o       = ctrl_q.jalr;
    assign illegal_instr_o = ctrl_q.illegal;
    assign stall_cnt_o     = cnt_q;
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Scoreboard bench for decode_ctrl_stage: table-driven RV32I reference, model of the
// handshake/hazard rules, and a second instance with a 2-bit counter for saturation.
module tb_decode_ctrl_stage;
    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu;
        logic        amux, bmux;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we, mreq, mwe;
        logic [1:0]  msz;
        logic        sext;
        logic [2:0]  br;
        logic [1:0]  wd;
        logic        jal, jalr, ill;
    } exp_t;

    typedef struct {
        logic        v, fl, rdy;
        logic [31:0] ins, pc;
        int          id;
    } stim_t;

    logic clk_i = 1'b0, rst_ni = 1'b0;
    logic [31:0] instr_i = 32'h0050_0093, pc_i = 32'h0;
    logic instr_valid_i = 1'b1, flush_i = 1'b0, ex_ready_i = 1'b1;
    logic instr_ready_o, ex_valid_o, data_a_mux_o, data_b_mux_o, reg_we_o, mem_req_o, mem_we_o;
    logic mem_sign_ext_o, jal_op_o, jalr_op_o, illegal_instr_o, stall_o;
    logic [31:0] pc_o, imm_o;
    logic [3:0]  alu_op_o;
    logic [4:0]  reg_raddr_a_o, reg_raddr_b_o, reg_waddr_o;
    logic [1:0]  mem_size_o, wdata_mux_o;
    logic [2:0]  branch_mux_o;
    logic [15:0] stall_cnt_o;
    logic s_ready, s_valid, s_amux, s_bmux, s_we, s_mreq, s_mwe, s_sext, s_jal, s_jalr, s_ill, s_stall;
    logic [31:0] s_pc, s_imm;
    logic [3:0]  s_alu;
    logic [4:0]  s_ra, s_rb, s_wa;
    logic [1:0]  s_msz, s_wd, s_cnt;
    logic [2:0]  s_br;

    always #5 clk_i = ~clk_i;

    decode_ctrl_stage u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .instr_i(instr_i), .pc_i(pc_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .flush_i(flush_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .pc_o(pc_o), .alu_op_o(alu_op_o),
        .data_a_mux_o(data_a_mux_o), .data_b_mux_o(data_b_mux_o), .imm_o(imm_o),
        .reg_raddr_a_o(reg_raddr_a_o), .reg_raddr_b_o(reg_raddr_b_o), .reg_waddr_o(reg_waddr_o),
        .reg_we_o(reg_we_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
        .mem_sign_ext_o(mem_sign_ext_o), .branch_mux_o(branch_mux_o), .wdata_mux_o(wdata_mux_o),
        .jal_op_o(jal_op_o), .jalr_op_o(jalr_op_o), .illegal_instr_o(illegal_instr_o),
        .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
    );

    decode_ctrl_stage #(.CNT_WIDTH(2)) u_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .instr_i(instr_i), .pc_i(pc_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(s_ready), .flush_i(flush_i),
        .ex_valid_o(s_valid), .ex_ready_i(ex_ready_i), .pc_o(s_pc), .alu_op_o(s_alu),
        .data_a_mux_o(s_amux), .data_b_mux_o(s_bmux), .imm_o(s_imm),
        .reg_raddr_a_o(s_ra), .reg_raddr_b_o(s_rb), .reg_waddr_o(s_wa),
        .reg_we_o(s_we), .mem_req_o(s_mreq), .mem_we_o(s_mwe), .mem_size_o(s_msz),
        .mem_sign_ext_o(s_sext), .branch_mux_o(s_br), .wdata_mux_o(s_wd),
        .jal_op_o(s_jal), .jalr_op_o(s_jalr), .illegal_instr_o(s_ill),
        .stall_o(s_stall), .stall_cnt_o(s_cnt)
    );

    int n_chk = 0, n_err = 0;
    exp_t sb[$];
    stim_t stim[$];
    bit m_valid = 0, m_load = 0;
    logic [4:0] m_rd = '0;
    int m_cnt = 0;

    // Reference tables indexed by funct3 (0 in br_tab means "no such branch").
    int br_tab  [8] = '{1, 2, 0, 0, 3, 4, 5, 6};
    int alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int sz_tab  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int sx_tab  [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
    logic [6:0] opcs [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h03, 7'h23,
                              7'h13, 7'h33, 7'h0F, 7'h73};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        int f3;
        logic [6:0] f7;
        logic [31:0] ii, is, ib, iu, ij;
        f3 = int'(ins[14:12]);
        f7 = ins[31:25];
        ii = {{20{ins[31]}}, ins[31:20]};
        is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iu = {ins[31:12], 12'h000};
        ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        e = '0;
        e.pc = pc;
        e.rd = ins[11:7];
        case (ins[6:0])
            7'h37: begin e.bmux = 1; e.imm = iu; e.we = 1; end
            7'h17: begin e.amux = 1; e.bmux = 1; e.imm = iu; e.we = 1; end
            7'h6F: begin e.amux = 1; e.bmux = 1; e.imm = ij; e.we = 1; e.wd = 2; e.jal = 1; end
            7'h67: begin e.bmux = 1; e.imm = ii; e.we = 1; e.wd = 2; e.jalr = 1; end
            7'h63: begin e.alu = 1; e.imm = ib; e.br = 3'(br_tab[f3]); e.ill = (br_tab[f3] == 0); end
            7'h03: begin
                e.bmux = 1; e.imm = ii; e.we = 1; e.wd = 1; e.mreq = 1;
                e.msz = 2'(sz_tab[f3]); e.sext = 1'(sx_tab[f3]);
                e.ill = !(f3 inside {0, 1, 2, 4, 5});
            end
            7'h23: begin e.bmux = 1; e.imm = is; e.mreq = 1; e.mwe = 1; e.msz = 2'(sz_tab[f3]); e.ill = (f3 > 2); end
            7'h13: begin
                e.bmux = 1; e.imm = ii; e.we = 1;
                e.alu = (f3 == 5 && f7[5]) ? 4'd7 : 4'(alu_tab[f3]);
                e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 inside {7'h00, 7'h20}));
            end
            7'h33: begin
                e.we = 1;
                e.alu = (f7[5] && f3 == 0) ? 4'd1 : (f7[5] && f3 == 5) ? 4'd7 : 4'(alu_tab[f3]);
                e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && f3 inside {0, 5}));
            end
            7'h0F, 7'h73: e.imm = ii;
            default: e.ill = 1;
        endcase
        if (e.ill) begin
            e.we = 0; e.mreq = 0; e.mwe = 0; e.msz = 0; e.sext = 0;
            e.br = 0; e.wd = 0; e.jal = 0; e.jalr = 0;
        end
        return e;
    endfunction

    function automatic bit uses_rs1(input logic [31:0] ins);
        return !(ins[6:0] inside {7'h37, 7'h17, 7'h6F});
    endfunction
    function automatic bit uses_rs2(input logic [31:0] ins);
        return ins[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic stim_t mk(input logic v, input logic [31:0] ins, input logic fl,
                                 input logic rdy, input int id);
        stim_t s;
        s.v = v; s.ins = ins; s.fl = fl; s.rdy = rdy; s.id = id;
        s.pc = 32'h100 + 32'(stim.size() * 4);
        return s;
    endfunction

    function automatic stim_t mk_rand();
        stim_t s;
        logic [31:0] ins;
        int r;
        ins = $urandom;
        ins[6:0] = ($urandom_range(0, 15) == 0) ? 7'($urandom) : opcs[$urandom_range(0, 11)];
        ins[11:7] = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        r = $urandom_range(0, 3);
        if (r == 0) ins[31:25] = 7'h00;
        else if (r == 1) ins[31:25] = 7'h20;
        s.v = ($urandom_range(0, 9) < 7);
        s.fl = ($urandom_range(0, 99) < 8);
        s.rdy = ($urandom_range(0, 3) != 0);
        s.ins = ins;
        s.pc = $urandom & 32'hFFFF_FFFC;
        s.id = 0;
        return s;
    endfunction

    task automatic run_rec(input stim_t r);
        bit haz, rdy;
        exp_t e;
        instr_valid_i = r.v; instr_i = r.ins; pc_i = r.pc; flush_i = r.fl; ex_ready_i = r.rdy;
        @(negedge clk_i);
        haz = m_valid && m_load && (m_rd != 0) &&
              ((uses_rs1(r.ins) && r.ins[19:15] == m_rd) || (uses_rs2(r.ins) && r.ins[24:20] == m_rd));
        rdy = r.fl || ((!m_valid || r.rdy) && !haz);
        chk("instr_ready", instr_ready_o, rdy);
        chk("stall", stall_o, haz && !r.fl);
        chk("ex_valid", ex_valid_o, m_valid);
        chk("stall_cnt", stall_cnt_o, 64'(m_cnt));
        chk("stall_cnt_sat", s_cnt, 64'((m_cnt > 3) ? 3 : m_cnt));
        chk("raddr_a", reg_raddr_a_o, (r.ins[6:0] == 7'h37) ? 64'd0 : 64'(r.ins[19:15]));
        chk("raddr_b", reg_raddr_b_o, 64'(r.ins[24:20]));
        case (r.id)
            1: begin
                chk("addi_alu", alu_op_o, 0); chk("addi_bmux", data_b_mux_o, 1);
                chk("addi_imm", imm_o, 5); chk("addi_we", reg_we_o, 1); chk("addi_rd", reg_waddr_o, 1);
            end
            2: chk("loaduse_cnt", stall_cnt_o, 1);
            3: chk("flush_clears", ex_valid_o, 0);
            4: begin chk("sat_cnt2", s_cnt, 3); chk("cnt16_after_6", stall_cnt_o, 6); end
            5: chk("flush_ready", instr_ready_o, 1);
            6: chk("bp_hold_pc", pc_o, 32'h100);
            default: ;
        endcase
        @(posedge clk_i);
        if (haz && !r.fl && m_cnt != 65535) m_cnt++;
        if (r.fl) begin
            if (m_valid && !r.rdy && sb.size() > 0) void'(sb.pop_back());
            m_valid = 0;
        end else if (r.v && rdy) begin
            e = ref_decode(r.ins, r.pc);
            sb.push_back(e);
            m_valid = 1; m_load = e.mreq && !e.mwe; m_rd = e.rd;
        end else if (r.rdy) begin
            m_valid = 0;
        end
        #1;
    endtask

    exp_t mon_e, mon_a;
    always @(negedge clk_i) begin
        if (rst_ni && ex_valid_o && ex_ready_i) begin
            mon_a = '{pc: pc_o, alu: alu_op_o, amux: data_a_mux_o, bmux: data_b_mux_o, imm: imm_o,
                      rd: reg_waddr_o, we: reg_we_o, mreq: mem_req_o, mwe: mem_we_o, msz: mem_size_o,
                      sext: mem_sign_ext_o, br: branch_mux_o, wd: wdata_mux_o, jal: jal_op_o,
                      jalr: jalr_op_o, ill: illegal_instr_o};
            n_chk++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: got output %h expected nothing at %0t", mon_a, $time);
            end else begin
                mon_e = sb.pop_front();
                if (mon_a !== mon_e) begin
                    n_err++;
                    $display("FAIL decode_out: got %h expected %h at %0t", mon_a, mon_e, $time);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) begin
            @(negedge clk_i);
            chk("rst_ex_valid", ex_valid_o, 0);
            chk("rst_cnt", stall_cnt_o, 0);
            chk("rst_pc", pc_o, 0);
        end
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        stim.push_back(mk(1, 32'h0050_0093, 0, 1, 0));
        stim.push_back(mk(1, 32'h0020_83B3, 0, 0, 1));
        stim.push_back(mk(1, 32'h0020_83B3, 0, 0, 6));
        stim.push_back(mk(1, 32'h0020_83B3, 0, 0, 6));
        stim.push_back(mk(1, 32'h0020_83B3, 0, 1, 0));
        stim.push_back(mk(1, 32'h0001_2283, 0, 1, 0));
        stim.push_back(mk(1, 32'h0012_8333, 0, 1, 0));
        stim.push_back(mk(1, 32'h0012_8333, 0, 1, 0));
        stim.push_back(mk(1, 32'h0001_2003, 0, 1, 2));
        stim.push_back(mk(1, 32'h0010_0333, 0, 1, 0));
        stim.push_back(mk(1, 32'h0020_8063, 0, 1, 0));
        stim.push_back(mk(1, 32'h0000_00EF, 1, 0, 5));
        stim.push_back(mk(0, 32'h0000_0000, 0, 1, 3));
        stim.push_back(mk(1, 32'h0020_F063, 0, 1, 0));
        stim.push_back(mk(1, 32'h0040_D183, 0, 1, 0));
        stim.push_back(mk(1, 32'h4020_D193, 0, 1, 0));
        stim.push_back(mk(1, 32'h0001_00E7, 0, 1, 0));
        stim.push_back(mk(1, 32'h0020_A063, 0, 1, 0));
        repeat (5) begin
            stim.push_back(mk(1, 32'h0001_2283, 0, 1, 0));
            stim.push_back(mk(1, 32'h0012_8333, 0, 1, 0));
            stim.push_back(mk(1, 32'h0012_8333, 0, 1, 0));
        end
        stim.push_back(mk(0, 32'h0000_0000, 0, 1, 4));
        repeat (1500) stim.push_back(mk_rand());
        repeat (2) stim.push_back(mk(0, 32'h0000_0013, 0, 1, 0));
        foreach (stim[i]) run_rec(stim[i]);
        chk("sb_drained", sb.size(), 0);

        // Leave a load held, then reset asynchronously mid-cycle.
        run_rec(mk(1, 32'h0001_2283, 0, 0, 0));
        run_rec(mk(1, 32'h0012_8333, 0, 0, 0));
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_ex_valid", ex_valid_o, 0);
        chk("midrst_cnt", stall_cnt_o, 0);
        chk("midrst_cnt_sat", s_cnt, 0);
        chk("midrst_pc", pc_o, 0);
        sb.delete();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
